mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one single-port synchronous memory bus between the instruction-fetch port and the MEM-stage data port of the OpenMIPS core, for a unified-memory SOPC.
- Serialises requests through a 3-state FSM.
- Inserts a fixed-latency wait window per access.
- Returns read data with a one-cycle ack pulse.
- Drives stall requests to the pipeline ctrl block until each port is serviced.

Parameters:
MEM_LAT, 1, cycles from bus_ce_o assertion to valid bus_rdata_i; legal 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
if_req_i  input  1  fetch request; held until if_ack_o
if_addr_i  input  32  fetch byte address
if_rdata_o  output  32  fetched instruction; valid with if_ack_o, held until next fetch ack
if_ack_o  output  1  one-cycle completion pulse, fetch port
mem_req_i  input  1  data request; held until mem_ack_o
mem_we_i  input  1  1 = write, 0 = read
mem_sel_i  input  4  byte enables
mem_addr_i  input  32  data byte address
mem_wdata_i  input  32  write data
mem_rdata_o  output  32  read data; valid with mem_ack_o, held until next data read ack
mem_ack_o  output  1  one-cycle completion pulse, data port
stallreq_if_o  output  1  fetch-port stall request to ctrl
stallreq_mem_o  output  1  data-port stall request to ctrl
bus_ce_o  output  1  memory chip enable
bus_we_o  output  1  memory write enable
bus_sel_o  output  4  memory byte enables
bus_addr_o  output  32  memory address, passed unmodified
bus_wdata_o  output  32  memory write data
bus_rdata_i  input  32  memory read data

Behaviour:
- Reset (rst=1 at a clk edge):
  - State to IDLE.
  - All registered outputs to 0: rdata, ack, bus_*.
  - Latency counter to 0, last-grant register to DATA.
  - Stall outputs forced 0 while rst=1.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_req_i=1, grant DATA. Else if if_req_i=1, grant IF. Else stay in IDLE.
  - On grant: latch the granted port's addr/we/sel/wdata into the bus_* registers, set bus_ce_o=1, load cnt=MEM_LAT, go to ACCESS.
  - IF grants always register bus_we_o=0 and bus_sel_o=4'b1111.
- ACCESS:
  - bus_* held stable.
  - cnt decrements each edge.
  - At the edge where cnt==1: if the grant is a read, capture bus_rdata_i into the granted port's rdata register. Then clear bus_ce_o and bus_we_o, and go to DONE.
- DONE:
  - Granted port's ack_o=1 for exactly this cycle.
  - Go to IDLE unconditionally: one bubble cycle, no back-to-back grant.
- Latency: request seen in IDLE at cycle T0 gives ack at T0+MEM_LAT+1. Throughput is one transaction per MEM_LAT+2 cycles.
- Stall outputs are combinational:
  - stallreq_if_o = if_req_i & ~if_ack_o & ~rst
  - stallreq_mem_o = mem_req_i & ~mem_ack_o & ~rst
- Writes: mem_rdata_o is unchanged; the ack is still pulsed.
- Request dropped mid-ACCESS: the transaction completes on the bus (writes are not aborted) and the ack still pulses. The requester ignores it.
- Requester inputs changing during ACCESS are ignored, because the bus regs are latched at grant.
- Both requests asserted in IDLE: arbitration follows the priority rule, fixed or round-robin (see Optional Feature). The loser waits with its stall asserted.
- Reset mid-ACCESS: abandons the transaction. bus_ce_o=0 from the next edge and no ack is issued.
- MEM_LAT outside 1..15 is a configuration error. Checked by an elaboration-time assertion in simulation.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both ports request in IDLE, grant goes to the port not recorded in last-grant. Last-grant updates on every grant, so alternating contention yields DATA, IF, DATA, ...
- Undefined: fixed priority, DATA always over IF. The last-grant register is not implemented.

Test Plan:
1. MEM_LAT=1, memory word 0x0000_0100 = 0x3401_1100; if_req_i=1, if_addr_i=0x100 at T0 -> bus_ce_o=1 at T1, if_ack_o=1 at T2 only, if_rdata_o=0x3401_1100, stallreq_if_o=1 at T0..T1 and 0 at T2.
2. MEM_LAT=3, mem write addr=0x20, sel=4'b0011, wdata=0xDEAD_BEEF -> bus_ce_o=bus_we_o=1 for 3 cycles, mem_ack_o at T0+4, memory bytes 0x20/0x21 = EF/BE, upper bytes unchanged, mem_rdata_o unchanged.
3. Both requesting at T0, MEM_LAT=1, fixed priority -> data ack at T2, IDLE at T3, IF granted at T3, if_ack_o at T5; stallreq_if_o high T0..T4.
4. With ARB_ROUND_ROBIN_EN, continuous contention for 6 transactions -> grant order DATA, IF, DATA, IF, DATA, IF; no ack in any bubble cycle.
5. rst=1 during ACCESS, MEM_LAT=4 -> bus_ce_o=0 at next edge, no ack ever, state IDLE; after rst=0, a fresh fetch completes normally.
6. mem_req_i dropped one cycle after grant (read, addr 0x40) -> mem_ack_o still pulses at T0+MEM_LAT+1; an if_req_i pending since T1 is granted at T0+MEM_LAT+2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous memory bus between the
// instruction-fetch port and the MEM-stage data port. Each access is granted
// in IDLE, held on the bus for MEM_LAT cycles in ACCESS, and acknowledged with
// a one-cycle pulse in DONE, which also acts as a bubble before the next grant.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants under
// contention; otherwise the data port always wins over the fetch port.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner onto the bus
// ACCESS | bus_* held stable while the latency counter runs down
// DONE   | granted port's ack pulses; always returns to IDLE
module mem_bus_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i
);

  // The counter is 4 bits wide, so latencies beyond 15 cannot be represented.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_bus_arbiter: MEM_LAT=%0d is outside 1..15", MEM_LAT);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       grant_data;
  logic       pick_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic       last_data;

  // Under contention the port that did not win last time is picked.
  always_comb begin
    pick_data = mem_req_i;
    if (mem_req_i && if_req_i) begin
      pick_data = ~last_data;
    end
  end

  // Last-grant record, updated on every grant; starts out as DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b1;
    end else if (state == IDLE && (mem_req_i || if_req_i)) begin
      last_data <= pick_data;
    end
  end
`else
  // Fixed priority: any data request beats a fetch request.
  always_comb begin
    pick_data = mem_req_i;
  end
`endif

  // Stall the pipeline while a request is outstanding and not yet acknowledged.
  assign stallreq_if_o  = if_req_i  & ~if_ack_o  & ~rst;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o & ~rst;

  // Transaction sequencer with registered bus, read-data and ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      grant_data  <= 1'b0;
      if_rdata_o  <= 32'd0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= 32'd0;
      mem_ack_o   <= 1'b0;
      bus_ce_o    <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'd0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_i || if_req_i) begin
            grant_data <= pick_data;
            bus_ce_o   <= 1'b1;
            cnt        <= 4'(MEM_LAT);
            state      <= ACCESS;
            if (pick_data) begin
              bus_we_o    <= mem_we_i;
              bus_sel_o   <= mem_sel_i;
              bus_addr_o  <= mem_addr_i;
              bus_wdata_o <= mem_wdata_i;
            end else begin
              bus_we_o    <= 1'b0;
              bus_sel_o   <= 4'b1111;
              bus_addr_o  <= if_addr_i;
              bus_wdata_o <= 32'd0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!bus_we_o) begin
              if (grant_data) begin
                mem_rdata_o <= bus_rdata_i;
              end else begin
                if_rdata_o  <= bus_rdata_i;
              end
            end
            mem_ack_o <= grant_data;
            if_ack_o  <= ~grant_data;
            bus_ce_o  <= 1'b0;
            bus_we_o  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          mem_ack_o <= 1'b0;
          if_ack_o  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic on both ports, all compared every cycle against a
// transaction-age reference model and a reference copy of memory.
module tb_mem_bus_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_ce;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MEM_LAT(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_rdata_o     (if_rdata),
    .if_ack_o       (if_ack),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .mem_rdata_o    (mem_rdata),
    .mem_ack_o      (mem_ack),
    .stallreq_if_o  (stall_if),
    .stallreq_mem_o (stall_mem),
    .bus_ce_o       (bus_ce),
    .bus_we_o       (bus_we),
    .bus_sel_o      (bus_sel),
    .bus_addr_o     (bus_addr),
    .bus_wdata_o    (bus_wdata),
    .bus_rdata_i    (bus_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h3401_1100;
      8:       return 32'h1122_3344;
      16:      return 32'hCAFE_0001;
      default: return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  // Memory device: 64 words, combinational read, byte-enabled write while ce&we.
  logic [31:0] dev_mem [64];
  assign bus_rdata = dev_mem[bus_addr[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) dev_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus_ce && bus_we)
        for (int b = 0; b < 4; b++)
          if (bus_sel[b]) dev_mem[bus_addr[7:2]][8*b +: 8] = bus_wdata[8*b +: 8];
    end
  end

  // Reference model: a transaction is described by its age in cycles since the
  // grant edge (age 1..LAT on the bus, age LAT+1 is the ack cycle, -1 idle).
  logic [31:0] ref_mem [64];
  int          age;
  bit          t_data;
  bit          t_we;
  bit          last_data;
  logic [3:0]  e_sel;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_if_rdata;
  logic [31:0] e_mem_rdata;

  initial begin
    bit pick;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    age = -1; t_data = 0; t_we = 0; last_data = 1;
    e_sel = '0; e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (age >= 1 && age <= LAT && t_we)
        for (int b = 0; b < 4; b++)
          if (e_sel[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
      if (rst) begin
        age = -1; last_data = 1;
        e_sel = '0; e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_mem_rdata = '0;
      end else if (age < 0) begin
        if (mem_req || if_req) begin
          pick = mem_req;
`ifdef ARB_ROUND_ROBIN_EN
          if (mem_req && if_req) pick = !last_data;
`endif
          last_data = pick;
          t_data    = pick;
          if (pick) begin
            t_we = mem_we; e_sel = mem_sel; e_addr = mem_addr; e_wdata = mem_wdata;
          end else begin
            t_we = 0; e_sel = 4'hF; e_addr = if_addr;
          end
          age = 1;
        end
      end else begin
        if (age == LAT && !t_we) begin
          if (t_data) e_mem_rdata = ref_mem[e_addr[7:2]];
          else        e_if_rdata  = ref_mem[e_addr[7:2]];
        end
        age = (age == LAT + 1) ? -1 : age + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    bit e_ce, e_ifack, e_mack;
    e_ce    = (age >= 1 && age <= LAT);
    e_ifack = (age == LAT + 1) && !t_data;
    e_mack  = (age == LAT + 1) && t_data;
    chk("m_bus_ce",    bus_ce,    e_ce);
    chk("m_bus_we",    bus_we,    e_ce && t_we);
    chk("m_if_ack",    if_ack,    e_ifack);
    chk("m_mem_ack",   mem_ack,   e_mack);
    chk("m_if_rdata",  if_rdata,  e_if_rdata);
    chk("m_mem_rdata", mem_rdata, e_mem_rdata);
    chk("m_stall_if",  stall_if,  if_req && !e_ifack && !rst);
    chk("m_stall_mem", stall_mem, mem_req && !e_mack && !rst);
    if (e_ce) begin
      chk("m_bus_addr", bus_addr, e_addr);
      chk("m_bus_sel",  bus_sel,  e_sel);
      if (t_we) chk("m_bus_wdata", bus_wdata, e_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    int a_cyc, b_cyc, n_if_ack, n_mem_ack;
    rst = 1; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
    mem_sel = '0; mem_addr = '0; mem_wdata = '0;

    // Reset: stalls forced low while rst is high, then everything zero.
    tick(); mid();
    tick(); mem_req = 1; if_req = 1; mid();
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    tick(); rst = 0; mem_req = 0; if_req = 0; mid();
    chk("rst_bus_ce", bus_ce, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_acks", {if_ack, mem_ack}, 0);
    chk("rst_rdata", if_rdata | mem_rdata, 0);

    // Single fetch.
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) begin if_req = 1; if_addr = 32'h10; end
      if (k == 5) if_req = 0;
      mid();
      chk("t1_if_ack", if_ack, k == 4);
      chk("t1_stall_if", stall_if, k < 4);
      if (k == 1) begin
        chk("t1_bus_ce", bus_ce, 1);
        chk("t1_bus_addr", bus_addr, 32'h10);
        chk("t1_bus_sel", bus_sel, 4'hF);
      end
      if (k == 4) chk("t1_if_rdata", if_rdata, 32'h3401_1100);
    end

    // Partial-byte write.
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) begin
        mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
      end
      if (k == 5) mem_req = 0;
      mid();
      chk("t2_mem_ack", mem_ack, k == 4);
      chk("t2_bus_we", bus_we, k >= 1 && k <= 3);
      chk("t2_stall_mem", stall_mem, k < 4);
      if (k == 4) chk("t2_mem_rdata", mem_rdata, 0);
    end
    chk("t2_mem_word", dev_mem[8], 32'h1122_BEEF);

    // Contention: both request in the same cycle.
`ifdef ARB_ROUND_ROBIN_EN
    a_cyc = 9; b_cyc = 4;
`else
    a_cyc = 4; b_cyc = 9;
`endif
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 0) begin
        mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h40;
        if_req = 1; if_addr = 32'h10;
      end
      if (k == a_cyc + 1) mem_req = 0;
      if (k == b_cyc + 1) if_req = 0;
      mid();
      chk("t3_mem_ack", mem_ack, k == a_cyc);
      chk("t3_if_ack", if_ack, k == b_cyc);
      chk("t3_stall_mem", stall_mem, k < a_cyc);
      chk("t3_stall_if", stall_if, k < b_cyc);
    end
    chk("t3_mem_rdata", mem_rdata, 32'hCAFE_0001);

    // Data request dropped after grant; fetch waits and follows.
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 0) begin mem_req = 1; mem_we = 0; mem_addr = 32'h40; end
      if (k == 1) begin mem_req = 0; mem_addr = 32'h80; if_req = 1; if_addr = 32'h14; end
      if (k == 10) if_req = 0;
      mid();
      chk("t6_mem_ack", mem_ack, k == 4);
      chk("t6_if_ack", if_ack, k == 9);
      if (k == 2) chk("t6_bus_addr_held", bus_addr, 32'h40);
      if (k == 5) chk("t6_bubble_ce", bus_ce, 0);
      if (k == 6) chk("t6_if_grant_addr", bus_addr, 32'h14);
      if (k == 9) chk("t6_if_rdata", if_rdata, init_word(5));
    end

    // Reset in the middle of a fetch.
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 0) begin if_req = 1; if_addr = 32'h10; end
      if (k == 2) rst = 1;
      if (k == 4) rst = 0;
      if (k == 9) if_req = 0;
      mid();
      chk("t5_if_ack", if_ack, k == 8);
      chk("t5_stall_if", stall_if, k < 8 && k != 2 && k != 3);
      if (k == 3) begin
        chk("t5_bus_ce", bus_ce, 0);
        chk("t5_if_rdata_clr", if_rdata, 0);
      end
      if (k == 8) chk("t5_if_rdata", if_rdata, 32'h3401_1100);
    end

    // Randomized traffic.
    n_if_ack = 0; n_mem_ack = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (if_req && if_ack)       if_req = 1'($urandom_range(0, 1));
      else if (if_req)            if_req = ($urandom_range(0, 29) != 0);
      else                        if_req = ($urandom_range(0, 2) == 0);
      if (mem_req && mem_ack)     mem_req = 1'($urandom_range(0, 1));
      else if (mem_req)           mem_req = ($urandom_range(0, 29) != 0);
      else                        mem_req = ($urandom_range(0, 2) == 0);
      mem_we    = 1'($urandom_range(0, 1));
      mem_sel   = 4'($urandom_range(0, 15));
      mem_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      mem_wdata = $urandom;
      if_addr   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      mid();
      if (if_ack)  n_if_ack++;
      if (mem_ack) n_mem_ack++;
    end
    chk("rand_if_acks_seen", 32'(n_if_ack > 0), 1);
    chk("rand_mem_acks_seen", 32'(n_mem_ack > 0), 1);
    for (int i = 0; i < 64; i++) chk("final_mem_word", dev_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
